// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Single-cycle multiply, XLEN-cycle restoring divide, registered result.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [1:0]      mul_ctrl,
    input  logic [1:0]      div_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [1:0]      mctl_q, mctl_d;
    logic            sel_rem_q, sel_rem_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            done_q, done_d;

    logic            accept;
    logic            sgn_div;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div0;
    logic            ovf;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    logic            mul_sa;
    logic            mul_sb;
    logic [2*XLEN-1:0] a_w;
    logic [2*XLEN-1:0] b_w;
    logic [2*XLEN-1:0] prod;

    assign accept  = (state_q == IDLE) && start && !flush;
    assign sgn_div = !div_ctrl[0];
    assign a_neg   = sgn_div && op_a[XLEN-1];
    assign b_neg   = sgn_div && op_b[XLEN-1];
    assign a_mag   = a_neg ? -op_a : op_a;
    assign b_mag   = b_neg ? -op_b : op_b;
    assign div0    = (op_b == '0);
    assign ovf     = sgn_div && (op_a == SMIN) && (op_b == '1);

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign rem_sh = {rem_q, a_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign ge     = (rem_sh >= {1'b0, b_q});
    assign rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx = {a_q[XLEN-2:0], ge};
    assign q_fin  = qneg_q ? -quo_nx : quo_nx;
    assign r_fin  = rneg_q ? -rem_nx : rem_nx;

    // Low 2*XLEN bits of the product of sign/zero-extended operands.
    assign mul_sa = (mctl_q != 2'b11);
    assign mul_sb = (mctl_q == 2'b00) || (mctl_q == 2'b01);
    assign a_w    = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
    assign b_w    = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
    assign prod   = a_w * b_w;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        res_d     = res_q;
        mctl_d    = mctl_q;
        sel_rem_d = sel_rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mctl_d    = mul_ctrl;
                    sel_rem_d = div_ctrl[1];
                    qneg_d    = a_neg ^ b_neg;
                    rneg_d    = a_neg;
                    cnt_d     = '0;
                    if (!is_div) begin
                        a_d     = op_a;
                        b_d     = op_b;
                        state_d = MUL;
                    end else if (div0) begin
                        res_d   = div_ctrl[1] ? op_a : '1;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (ovf) begin
                        res_d   = div_ctrl[1] ? '0 : SMIN;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        rem_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    res_d   = (mctl_q == 2'b00) ? prod[XLEN-1:0]
                                                : prod[2*XLEN-1:XLEN];
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DIV: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        res_d   = sel_rem_q ? r_fin : q_fin;
                        cnt_d   = '0;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            mctl_q    <= '0;
            sel_rem_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            mctl_q    <= mctl_d;
            sel_rem_q <= sel_rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            done_q    <= done_d;
        end
    end

    assign stall  = rst_n && (accept || (state_q == MUL) || (state_q == DIV));
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every
// cycle, plus directed cases with hand-computed values and latencies.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_div = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  mul_ctrl = 2'b00;
    logic [1:0]  div_ctrl = 2'b00;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .is_div(is_div),
        .mul_ctrl(mul_ctrl),
        .div_ctrl(div_ctrl),
        .op_a(op_a),
        .op_b(op_b),
        .flush(flush),
        .stall(stall),
        .done(done),
        .result(result)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_calc(input logic d, input logic [1:0] mc,
                                             input logic [1:0] dc,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [65:0] sa, sb, p;
        logic signed [63:0] x, y, q, r;
        if (!d) begin
            sa = (mc == 2'b11) ? {34'b0, a} : {{34{a[31]}}, a};
            sb = (mc == 2'b00 || mc == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
            p = sa * sb;
            return (mc == 2'b00) ? p[31:0] : p[63:32];
        end
        if (b == 32'h0) begin
            q = '1;
            r = {32'b0, a};
        end else if (!dc[0]) begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
            q = x / y;
            r = x % y;
        end else begin
            x = {32'b0, a};
            y = {32'b0, b};
            q = x / y;
            r = x % y;
        end
        return dc[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic d, input logic [1:0] dc,
                                   input logic [31:0] a, input logic [31:0] b);
        if (!d) return 2;
        if (b == 32'h0) return 1;
        if (!dc[0] && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
        return 33;
    endfunction

    // Model: busy flag, cycles left before the done cycle, visible result.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_wait = 0;
            m_res  = '0;
        end else if (m_busy) begin
            if (flush || m_wait == 0) begin
                m_busy = 1'b0;
            end else begin
                m_wait--;
                if (m_wait == 0) m_res = m_pend;
            end
        end else if (start && !flush) begin
            m_pend = ref_calc(is_div, mul_ctrl, div_ctrl, op_a, op_b);
            m_wait = ref_lat(is_div, div_ctrl, op_a, op_b) - 1;
            m_busy = 1'b1;
            if (m_wait == 0) m_res = m_pend;
        end
    end

    always @(negedge clk) begin
        logic e_done, e_stall;
        e_done  = m_busy && (m_wait == 0);
        e_stall = rst_n && (m_busy ? (m_wait > 0) : (start && !flush));
        chk("model_done", {31'b0, done}, {31'b0, e_done});
        chk("model_stall", {31'b0, stall}, {31'b0, e_stall});
        chk("model_result", result, m_res);
    end

    // Starts and ends 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input string nm, input logic d, input logic [1:0] mc,
                          input logic [1:0] dc, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat);
        int lat = 0;
        int k = 0;
        int scnt = 0;
        is_div = d;
        mul_ctrl = mc;
        div_ctrl = dc;
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (lat == 0 && k < 40) begin
            k++;
            @(negedge clk);
            if (done) begin
                lat = k;
            end else begin
                if (stall) scnt++;
                @(posedge clk);
                #1;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL %s_timeout: no done within 40 cycles", nm);
        end else begin
            chk(nm, result, exp);
            chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({nm, "_stall"}, 32'(scnt), 32'(exp_lat - 1));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hffff_ffff;
            3: return 32'($urandom % 16);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result", result, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("mulh_m1", 1'b0, 2'b01, 2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'h0, 2);
        run_op("mulhu_m1", 1'b0, 2'b11, 2'b00, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 2);
        run_op("div_m7_2", 1'b1, 2'b00, 2'b00, 32'hffff_fff9, 32'h2, 32'hffff_fffd, 33);
        run_op("rem_m7_2", 1'b1, 2'b00, 2'b10, 32'hffff_fff9, 32'h2, 32'hffff_ffff, 33);
        run_op("divu_by0", 1'b1, 2'b00, 2'b01, 32'h5, 32'h0, 32'hffff_ffff, 1);
        run_op("remu_by0", 1'b1, 2'b00, 2'b11, 32'h5, 32'h0, 32'h5, 1);
        run_op("div_ovf", 1'b1, 2'b00, 2'b00, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1);
        run_op("rem_ovf", 1'b1, 2'b00, 2'b10, 32'h8000_0000, 32'hffff_ffff, 32'h0, 1);
        run_op("div_100_7", 1'b1, 2'b00, 2'b00, 32'd100, 32'd7, 32'd14, 33);

        // Flush a divide at iteration 10.
        is_div = 1'b1;
        div_ctrl = 2'b00;
        op_a = 32'd1000;
        op_b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_done", {31'b0, done}, 32'h0);
            chk("flush_stall", {31'b0, stall}, 32'h0);
            chk("flush_result", result, 32'd14);
            @(posedge clk);
            #1;
        end
        run_op("mul_3x4", 1'b0, 2'b00, 2'b00, 32'd3, 32'd4, 32'd12, 2);

        // Reset in the middle of a divide.
        is_div = 1'b1;
        div_ctrl = 2'b01;
        op_a = 32'd77;
        op_b = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'b0, stall}, 32'h0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_done", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("mul_after_rst", 1'b0, 2'b00, 2'b00, 32'd6, 32'd7, 32'd42, 2);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            start    = ($urandom % 3 == 0);
            is_div   = 1'($urandom);
            mul_ctrl = 2'($urandom);
            div_ctrl = 2'($urandom);
            op_a     = pick();
            op_b     = pick();
            flush    = ($urandom % 25 == 0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
